// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - N-channel round-robin memory arbiter with request/accept/ack handshake
// Optional MEM_RR_ARB_PRIO_EN adds chPrio: eligible high-priority channels are scanned exclusively.
module mem_rr_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CH_BITS    = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            chReq,
  input  logic [NUM_CH-1:0]            chWr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] chAddr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] chWData,
`ifdef MEM_RR_ARB_PRIO_EN
  input  logic [NUM_CH-1:0]            chPrio,
`endif
  output logic [NUM_CH-1:0]            chReady,
  output logic [DATA_WIDTH-1:0]        chRData,
  output logic [CH_BITS-1:0]           grantId,
  output logic                         grantValid,
  output logic                         memReq,
  output logic                         memWr,
  output logic [ADDR_WIDTH-1:0]        memAddr,
  output logic [DATA_WIDTH-1:0]        memDataIn,
  input  logic                         memBusy,
  input  logic                         memAck,
  input  logic [DATA_WIDTH-1:0]        memDataOut
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state_q, state_d;
  logic [CH_BITS-1:0]    last_grant_q, last_grant_d;
  logic [CH_BITS-1:0]    grant_id_q, grant_id_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_CH-1:0]     ch_ready_q, ch_ready_d;
  logic [DATA_WIDTH-1:0] ch_rdata_q, ch_rdata_d;

  logic [NUM_CH-1:0]     eligible;
  logic [NUM_CH-1:0]     scan_set;
  logic                  found;
  logic [CH_BITS-1:0]    pick;
  logic [CH_BITS-1:0]    cand;
  int                    idx;

  // A channel whose completion pulse is high this cycle sits out one arbitration round.
  always_comb begin
    eligible = chReq & ~ch_ready_q;
`ifdef MEM_RR_ARB_PRIO_EN
    scan_set = (|(eligible & chPrio)) ? (eligible & chPrio) : eligible;
`else
    scan_set = eligible;
`endif
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_BITS'(idx);
      if (!found && scan_set[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ch_ready_d   = '0;
    ch_rdata_d   = ch_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = pick;
          wr_d       = chWr[pick];
          addr_d     = chAddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d    = chWData[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!memBusy) state_d = WAIT;
      end
      WAIT: begin
        if (memAck) begin
          ch_rdata_d   = memDataOut;
          ch_ready_d   = NUM_CH'(1) << grant_id_q;
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= CH_BITS'(NUM_CH - 1);
      grant_id_q   <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ch_ready_q   <= '0;
      ch_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ch_ready_q   <= ch_ready_d;
      ch_rdata_q   <= ch_rdata_d;
    end
  end

  // Handshake outputs decode straight from state so reset drops them without waiting for a clock.
  assign memReq     = (state_q == ISSUE);
  assign grantValid = (state_q != IDLE);
  assign grantId    = grant_id_q;
  assign memWr      = wr_q;
  assign memAddr    = addr_q;
  assign memDataIn  = wdata_q;
  assign chReady    = ch_ready_q;
  assign chRData    = ch_rdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - directed scoreboard bench for mem_rr_arbiter
module tb_mem_rr_arbiter;
  localparam int NUM_CH = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int CB     = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    chReq, chWr;
  logic [NUM_CH*AW-1:0] chAddr;
  logic [NUM_CH*DW-1:0] chWData;
`ifdef MEM_RR_ARB_PRIO_EN
  logic [NUM_CH-1:0]    chPrio;
`endif
  logic [NUM_CH-1:0]    chReady;
  logic [DW-1:0]        chRData;
  logic [CB-1:0]        grantId;
  logic                 grantValid, memReq, memWr;
  logic [AW-1:0]        memAddr;
  logic [DW-1:0]        memDataIn;
  logic                 memBusy, memAck;
  logic [DW-1:0]        memDataOut;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .chReq(chReq), .chWr(chWr), .chAddr(chAddr), .chWData(chWData),
`ifdef MEM_RR_ARB_PRIO_EN
    .chPrio(chPrio),
`endif
    .chReady(chReady), .chRData(chRData), .grantId(grantId), .grantValid(grantValid),
    .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memDataIn(memDataIn),
    .memBusy(memBusy), .memAck(memAck), .memDataOut(memDataOut)
  );

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int          busy_left = 0;
  int          ack_wait  = 0;
  int          wait_left = 0;
  int          accepts   = 0;
  bit          pend      = 1'b0;
  logic [31:0] acc_addr  = '0;
  logic        s_req, s_busy;
  logic [31:0] s_addr;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'hC0DE_0000) + 32'd7);
  endfunction

  // Memory model: samples the handshake before each edge, answers just after it.
  initial begin
    memBusy = 1'b0; memAck = 1'b0; memDataOut = '0;
    forever begin
      @(negedge clk);
      s_req = memReq; s_busy = memBusy; s_addr = memAddr;
      @(posedge clk); #1;
      memAck = 1'b0;
      if (!reset) begin
        pend = 1'b0; memBusy = 1'b0;
      end else begin
        if (s_req && !s_busy) begin
          accepts++; pend = 1'b1; wait_left = ack_wait; acc_addr = s_addr;
        end
        if (pend) begin
          if (wait_left == 0) begin
            memAck = 1'b1; memDataOut = mem_model(acc_addr); pend = 1'b0;
          end else wait_left--;
        end
        if (memReq && busy_left > 0) begin
          memBusy = 1'b1; busy_left--;
        end else memBusy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int ch, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    chWr[ch]             = wr;
    chAddr[ch*AW +: AW]  = addr;
    chWData[ch*DW +: DW] = data;
    chReq[ch]            = 1'b1;
  endtask

  task automatic req(input int ch, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    drive(ch, wr, addr, data);
    sb.push_back('{ch: ch, wr: wr, data: (wr ? 32'h0 : mem_model(addr))});
  endtask

  task automatic check_ready(input string tag);
    exp_t e;
    int   got = 0;
    chk({tag, "_onehot"}, 64'($onehot(chReady)), 64'd1);
    for (int i = 0; i < NUM_CH; i++) if (chReady[i]) got = i;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_ready"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_ch"}, 64'(got), 64'(e.ch));
    if (!e.wr) chk({tag, "_rdata"}, 64'(chRData), 64'(e.data));
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      step();
      if (chReady != '0) begin
        check_ready(tag);
        seen++;
      end
    end
    chk({tag, "_count"}, 64'(seen), 64'(n));
  endtask

  initial begin
    int base;
    reset = 1'b0; chReq = '0; chWr = '0; chAddr = '0; chWData = '0;
`ifdef MEM_RR_ARB_PRIO_EN
    chPrio = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_memReq", 64'(memReq), 64'd0);
    chk("rst_grantValid", 64'(grantValid), 64'd0);
    chk("rst_grantId", 64'(grantId), 64'd0);
    chk("rst_chReady", 64'(chReady), 64'd0);
    chk("rst_chRData", 64'(chRData), 64'd0);
    chk("rst_memWr", 64'(memWr), 64'd0);
    chk("rst_memAddr", 64'(memAddr), 64'd0);
    chk("rst_memDataIn", 64'(memDataIn), 64'd0);
    reset = 1'b1;
    step();

    // All channels request at reset exit: order 0,1,2,3,0.
    for (int ch = 0; ch < NUM_CH; ch++) req(ch, 1'b0, 32'h1000 + 32'(ch) * 32'h10, 32'h0);
    sb.push_back('{ch: 0, wr: 1'b0, data: mem_model(32'h1000)});
    run_until("rr", 5, 40);
    chReq = '0;
    step();
    chk("rr_idle", 64'(grantValid), 64'd0);
    chk("rr_sb_empty", 64'(sb.size()), 64'd0);

    // Single read with minimum latency.
    req(2, 1'b0, 32'h100, 32'h0);
    step();
    chk("sr_grantValid", 64'(grantValid), 64'd1);
    chk("sr_grantId", 64'(grantId), 64'd2);
    chk("sr_memReq", 64'(memReq), 64'd1);
    chk("sr_memAddr", 64'(memAddr), 64'h100);
    step();
    chk("sr_accepted", 64'(memReq), 64'd0);
    step();
    chk("sr_chReady", 64'(chReady), 64'b0100);
    check_ready("sr");
    chReq = '0;
    step();
    chk("sr_pulse_end", 64'(chReady), 64'd0);

    // Write from ch1, held through its completion to exercise masking.
    req(1, 1'b1, 32'h40, 32'h12345678);
    step();
    chk("wr_memReq", 64'(memReq), 64'd1);
    chk("wr_memWr", 64'(memWr), 64'd1);
    chk("wr_memAddr", 64'(memAddr), 64'h40);
    chk("wr_memDataIn", 64'(memDataIn), 64'h12345678);
    step();
    step();
    chk("wr_chReady", 64'(chReady), 64'b0010);
    check_ready("wr");
    sb.push_back('{ch: 1, wr: 1'b1, data: 32'h0});
    step();
    chk("wr_masked", 64'(grantValid), 64'd0);
    step();
    chk("wr_regrant_valid", 64'(grantValid), 64'd1);
    chk("wr_regrant_id", 64'(grantId), 64'd1);
    chReq = '0; chWr = '0;
    run_until("wr2", 1, 20);

    // memBusy for 5 cycles in ISSUE.
    busy_left = 5;
    base = accepts;
    req(0, 1'b0, 32'h200, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("busy_memReq", 64'(memReq), 64'd1);
      chk("busy_memAddr", 64'(memAddr), 64'h200);
    end
    step();
    chk("busy_released", 64'(memReq), 64'd0);
    step();
    chk("busy_accepts", 64'(accepts - base), 64'd1);
    chk("busy_chReady", 64'(chReady), 64'b0001);
    check_ready("busy");
    chReq = '0;

    // Reset during WAIT abandons ch0; pending ch3 is served afterwards.
    ack_wait = 10;
    step();
    drive(0, 1'b0, 32'h300, 32'h0);
    step();
    chk("rw_grant0", 64'(grantId), 64'd0);
    chReq[0] = 1'b0;
    step();
    chk("rw_in_wait", 64'(grantValid), 64'd1);
    req(3, 1'b0, 32'h340, 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("rw_memReq", 64'(memReq), 64'd0);
    chk("rw_grantValid", 64'(grantValid), 64'd0);
    chk("rw_chReady", 64'(chReady), 64'd0);
    ack_wait = 0;
    step();
    step();
    reset = 1'b1;
    run_until("rw_ch3", 1, 20);
    chReq = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rw_no_ghost", 64'(chReady), 64'd0);
    end

`ifdef MEM_RR_ARB_PRIO_EN
    // ch0 would win on round-robin alone; priority puts ch3 first.
    chPrio = 4'b1000;
    drive(0, 1'b0, 32'h500, 32'h0);
    drive(3, 1'b0, 32'h530, 32'h0);
    sb.push_back('{ch: 3, wr: 1'b0, data: mem_model(32'h530)});
    sb.push_back('{ch: 0, wr: 1'b0, data: mem_model(32'h500)});
    run_until("prio", 2, 30);
    chReq = '0; chPrio = '0;
`endif

    step();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Parametrised N-channel memory arbiter: successor to the fixed two-channel (instruction/data) TDM arbiter. It multiplexes NUM_CH requesters onto a single memory port using round-robin grant with a request/accept/acknowledge handshake, and returns registered read data to the winner. It sits between the core's fetch/load-store units (plus DMA or debug masters) and the memory interface.

## Interface
Parameters:
- NUM_CH, 4, number of requesting channels (2..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- CH_BITS, $clog2(NUM_CH), grant index width (derived, do not override)

Ports (flattened buses: channel i at [i*W +: W]):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- chReq  in  NUM_CH  per-channel request, held until chReady
- chWr  in  NUM_CH  1 = write, 0 = read
- chAddr  in  NUM_CH*ADDR_WIDTH  per-channel address
- chWData  in  NUM_CH*DATA_WIDTH  per-channel write data
- chReady  out  NUM_CH  one-cycle completion pulse, one-hot
- chRData  out  DATA_WIDTH  registered read data, valid while chReady is non-zero
- grantId  out  CH_BITS  channel currently owning the memory port
- grantValid  out  1  a transaction is in flight (ISSUE or WAIT)
- memReq  out  1  memory request
- memWr  out  1  memory write enable
- memAddr  out  ADDR_WIDTH  memory address
- memDataIn  out  DATA_WIDTH  write data to memory
- memBusy  in  1  memory cannot accept this cycle
- memAck  in  1  memory completion pulse
- memDataOut  in  DATA_WIDTH  read data, valid with memAck

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**:
  - Eligible set = chReq & ~chReady.
  - If the set is non-empty, select the first eligible channel scanning upward from lastGrant+1 (mod NUM_CH).
  - Latch grantId, wr, addr and wdata from that channel into internal registers, then go to ISSUE.
- **ISSUE**:
  - memReq=1; memWr, memAddr and memDataIn are driven from the latched registers.
  - Accept occurs when memReq && !memBusy at a clock edge, then go to WAIT.
- **WAIT**:
  - memReq=0.
  - On memAck: capture memDataOut into chRData, pulse chReady[grantId] for one cycle, set lastGrant=grantId, go to IDLE.
  - For writes, chRData is still loaded from memDataOut; its value is don't-care.
- Requester inputs are sampled only in IDLE. Changes to them after the grant do not affect the transaction in flight.
- A memAck arriving outside WAIT is ignored.
- Reset values:
  - state=IDLE; lastGrant=NUM_CH-1, so channel 0 wins first.
  - grantId=0, grantValid=0, memReq=0, memWr=0, memAddr=0, memDataIn=0, chReady=0, chRData=0.
- Reset asserted mid-transaction: the transaction is abandoned and memReq drops asynchronously. No chReady is issued for it.

## Timing
- Minimum latency: chReq high at edge 0 → ISSUE after edge 1 → accept at edge 2 (memBusy=0) → memAck sampled at edge 3 → chReady high after edge 3. Total is 3 cycles plus memory wait cycles.
- Each cycle memBusy=1 in ISSUE adds one cycle. Each cycle without memAck in WAIT adds one cycle.
- Throughput: at most one transaction per 3 cycles.
- Masking rule: a channel is not eligible in the cycle its chReady is high. Holding chReq high through that cycle issues a new request one cycle later.
- Fairness: any continuously requesting channel is granted within NUM_CH transactions.
- Simultaneous requests at reset exit: channel 0 is granted, then 1, 2, and so on.

## Configuration
- MEM_RR_ARB_PRIO_EN defined:
  - Adds input chPrio [NUM_CH].
  - In IDLE, if any eligible channel has chPrio=1, the round-robin scan covers only those channels.
  - lastGrant updates as normal.
  - Starvation of low-priority channels is permitted.
- Not defined: the port is absent and arbitration is pure round-robin.

## Test plan
- Single read: ch2 reads 0x100, memDataOut=0xDEADBEEF with memAck in the cycle after accept → chReady=4'b0100 three cycles after chReq, chRData=0xDEADBEEF, grantId=2.
- All four channels request continuously after reset → grant order 0,1,2,3,0. Each chReady is one-hot with one pulse per transaction.
- memBusy held high for 5 cycles in ISSUE → memReq stays high with a stable address for 6 cycles. Exactly one accept, and chReady is delayed by 5 cycles.
- Write from ch1 (addr 0x40, data 0x12345678) → memWr=1, memAddr=0x40, memDataIn=0x12345678 while memReq is high. ch1 is excluded from arbitration during its chReady cycle.
- reset driven low during WAIT → memReq, grantValid and chReady go 0 immediately. After release, a pending ch3 request is served with no ghost chReady.
- With MEM_RR_ARB_PRIO_EN: ch0 and ch3 request with chPrio=4'b1000 → ch3 is granted first, then ch0.
